// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: opcode set, ROB tag width,
// entry/dispatch payloads and the CDB snoop helper.
package reservation_station_pkg;

    localparam int unsigned ENTRY_W = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 6;

    typedef logic [ENTRY_W-1:0] tag_t;

    typedef enum logic [OP_W-1:0] {
        BEQ = 6'd0, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LUI, AUIPC
    } op_e;

    typedef struct packed {
        logic              valid;
        tag_t              tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic              busy;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic              qj_busy;
        logic              qk_busy;
        tag_t              qj;
        tag_t              qk;
        tag_t              dest;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        tag_t              dest;
    } rs_dispatch_t;

    // A pending operand captures the first matching broadcast; the ALU bus wins ties.
    function automatic operand_t snoop(operand_t cur, tag_t tag, cdb_t alu, cdb_t lsb);
        operand_t res;
        res = cur;
        if (cur.busy) begin
            if (alu.valid && alu.tag == tag) begin
                res.busy = 1'b0;
                res.val  = alu.data;
            end else if (lsb.valid && lsb.tag == tag) begin
                res.busy = 1'b0;
                res.val  = lsb.data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority encoder: returns the first set request and a found flag.
module rs_select #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]         req_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);

    localparam int unsigned IDX_W = $clog2(N);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: issue into the lowest free slot, wake operands from
// the ALU/LSB result buses, dispatch the lowest ready slot one per cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                clear,
    input  logic                issue_valid,
    input  logic [OP_W-1:0]     issue_op,
    input  logic [DATA_W-1:0]   issue_instruction,
    input  logic [DATA_W-1:0]   issue_pc,
    input  logic [DATA_W-1:0]   issue_imm,
    input  logic [DATA_W-1:0]   issue_vj,
    input  logic [DATA_W-1:0]   issue_vk,
    input  logic                issue_qj_busy,
    input  logic                issue_qk_busy,
    input  logic [ENTRY_W-1:0]  issue_qj,
    input  logic [ENTRY_W-1:0]  issue_qk,
    input  logic [ENTRY_W-1:0]  issue_entry,
    output logic                rs_full,
    input  logic                alu_broadcast,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [ENTRY_W-1:0]  alu_entry_in,
    input  logic                lsb_broadcast,
    input  logic [DATA_W-1:0]   lsb_result,
    input  logic [ENTRY_W-1:0]  lsb_entry_in,
    output logic                new_calculate,
    output logic [OP_W-1:0]     out_op,
    output logic [DATA_W-1:0]   out_instruction,
    output logic [DATA_W-1:0]   out_vj,
    output logic [DATA_W-1:0]   out_vk,
    output logic [DATA_W-1:0]   out_pc,
    output logic [DATA_W-1:0]   out_imm,
    output logic [ENTRY_W-1:0]  out_entry
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    rs_entry_t    entries_q [RS_SIZE];
    rs_entry_t    entries_d [RS_SIZE];
    rs_dispatch_t out_q, out_d;
    logic         new_calc_q, new_calc_d;

    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic [IDX_W-1:0]   free_idx, ready_idx;
    logic               free_found, ready_found;
    cdb_t               alu_cdb, lsb_cdb;
    operand_t           opj, opk;

    assign alu_cdb = '{valid: alu_broadcast, tag: alu_entry_in, data: alu_result};
    assign lsb_cdb = '{valid: lsb_broadcast, tag: lsb_entry_in, data: lsb_result};

    // Free/ready vectors come from registered state only.
    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            free_vec[i]  = ~entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy & ~entries_q[i].qj_busy & ~entries_q[i].qk_busy;
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req_i   (ready_vec),
        .idx_o   (ready_idx),
        .found_o (ready_found)
    );

    assign rs_full = ~free_found;

    always_comb begin
        entries_d  = entries_q;
        out_d      = out_q;
        new_calc_d = 1'b0;
        opj        = '0;
        opk        = '0;
        if (rdy) begin
            if (clear) begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    entries_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    if (entries_q[i].busy) begin
                        opj = snoop('{busy: entries_q[i].qj_busy, val: entries_q[i].vj},
                                    entries_q[i].qj, alu_cdb, lsb_cdb);
                        opk = snoop('{busy: entries_q[i].qk_busy, val: entries_q[i].vk},
                                    entries_q[i].qk, alu_cdb, lsb_cdb);
                        entries_d[i].qj_busy = opj.busy;
                        entries_d[i].vj      = opj.val;
                        entries_d[i].qk_busy = opk.busy;
                        entries_d[i].vk      = opk.val;
                    end
                end
                if (ready_found) begin
                    out_d = '{op:    entries_q[ready_idx].op,
                              instr: entries_q[ready_idx].instr,
                              pc:    entries_q[ready_idx].pc,
                              imm:   entries_q[ready_idx].imm,
                              vj:    entries_q[ready_idx].vj,
                              vk:    entries_q[ready_idx].vk,
                              dest:  entries_q[ready_idx].dest};
                    new_calc_d = 1'b1;
                    entries_d[ready_idx].busy = 1'b0;
                end
                // Slot freed by this edge's dispatch is not in free_vec, so no collision.
                if (issue_valid && free_found) begin
                    opj = snoop('{busy: issue_qj_busy, val: issue_vj}, issue_qj, alu_cdb, lsb_cdb);
                    opk = snoop('{busy: issue_qk_busy, val: issue_vk}, issue_qk, alu_cdb, lsb_cdb);
                    entries_d[free_idx] = '{busy:    1'b1,
                                            op:      issue_op,
                                            instr:   issue_instruction,
                                            pc:      issue_pc,
                                            imm:     issue_imm,
                                            vj:      opj.val,
                                            vk:      opk.val,
                                            qj_busy: opj.busy,
                                            qk_busy: opk.busy,
                                            qj:      issue_qj,
                                            qk:      issue_qk,
                                            dest:    issue_entry};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries_q[i] <= '0;
            end
            out_q      <= '0;
            new_calc_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                entries_q[i] <= entries_d[i];
            end
            out_q      <= out_d;
            new_calc_q <= new_calc_d;
        end
    end

    assign new_calculate   = new_calc_q;
    assign out_op          = out_q.op;
    assign out_instruction = out_q.instr;
    assign out_vj          = out_q.vj;
    assign out_vk          = out_q.vk;
    assign out_pc          = out_q.pc;
    assign out_imm         = out_q.imm;
    assign out_entry       = out_q.dest;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus a randomized run
// checked against an array-based behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int RS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rdy, clear, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_instruction, issue_pc, issue_imm, issue_vj, issue_vk;
    logic        issue_qj_busy, issue_qk_busy;
    logic [3:0]  issue_qj, issue_qk, issue_entry;
    logic        rs_full;
    logic        alu_broadcast, lsb_broadcast;
    logic [31:0] alu_result, lsb_result;
    logic [3:0]  alu_entry_in, lsb_entry_in;
    logic        new_calculate;
    logic [5:0]  out_op;
    logic [31:0] out_instruction, out_vj, out_vk, out_pc, out_imm;
    logic [3:0]  out_entry;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    bit          m_busy [RS];
    logic [5:0]  m_op   [RS];
    logic [31:0] m_ins [RS], m_pc [RS], m_imm [RS], m_vj [RS], m_vk [RS];
    bit          m_qjb [RS], m_qkb [RS];
    logic [3:0]  m_qj [RS], m_qk [RS], m_dest [RS];
    bit          m_nc;
    logic [5:0]  mo_op;
    logic [31:0] mo_ins, mo_vj, mo_vk, mo_pc, mo_imm;
    logic [3:0]  mo_dest;

    reservation_station #(.RS_SIZE(16)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_instruction(issue_instruction), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_entry(issue_entry),
        .rs_full(rs_full),
        .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry_in(alu_entry_in),
        .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry_in(lsb_entry_in),
        .new_calculate(new_calculate), .out_op(out_op), .out_instruction(out_instruction),
        .out_vj(out_vj), .out_vk(out_vk), .out_pc(out_pc), .out_imm(out_imm),
        .out_entry(out_entry)
    );

    always #5 clk = ~clk;

    function automatic bit hit(logic v, logic [3:0] bus_tag, logic [3:0] want);
        return v && (bus_tag == want);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
        m_nc = 1'b0; mo_op = '0; mo_ins = '0; mo_vj = '0; mo_vk = '0;
        mo_pc = '0; mo_imm = '0; mo_dest = '0;
    endtask

    // One clock edge of the abstract machine, evaluated from the current inputs.
    task automatic model_step();
        int disp;
        int free;
        disp = -1;
        free = -1;
        if (!rdy) begin m_nc = 1'b0; return; end
        if (clear) begin
            for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
            m_nc = 1'b0;
            return;
        end
        for (int i = 0; i < RS; i++) begin
            if (disp < 0 && m_busy[i] && !m_qjb[i] && !m_qkb[i]) disp = i;
            if (free < 0 && !m_busy[i]) free = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (!m_busy[i]) continue;
            if (m_qjb[i] && hit(alu_broadcast, alu_entry_in, m_qj[i])) begin m_vj[i] = alu_result; m_qjb[i] = 0; end
            else if (m_qjb[i] && hit(lsb_broadcast, lsb_entry_in, m_qj[i])) begin m_vj[i] = lsb_result; m_qjb[i] = 0; end
            if (m_qkb[i] && hit(alu_broadcast, alu_entry_in, m_qk[i])) begin m_vk[i] = alu_result; m_qkb[i] = 0; end
            else if (m_qkb[i] && hit(lsb_broadcast, lsb_entry_in, m_qk[i])) begin m_vk[i] = lsb_result; m_qkb[i] = 0; end
        end
        m_nc = (disp >= 0);
        if (disp >= 0) begin
            mo_op = m_op[disp]; mo_ins = m_ins[disp]; mo_vj = m_vj[disp]; mo_vk = m_vk[disp];
            mo_pc = m_pc[disp]; mo_imm = m_imm[disp]; mo_dest = m_dest[disp];
            m_busy[disp] = 1'b0;
        end
        if (issue_valid && free >= 0) begin
            m_busy[free] = 1'b1; m_op[free] = issue_op; m_ins[free] = issue_instruction;
            m_pc[free] = issue_pc; m_imm[free] = issue_imm; m_dest[free] = issue_entry;
            m_qj[free] = issue_qj; m_qk[free] = issue_qk;
            m_vj[free] = issue_vj; m_qjb[free] = issue_qj_busy;
            m_vk[free] = issue_vk; m_qkb[free] = issue_qk_busy;
            if (issue_qj_busy && hit(alu_broadcast, alu_entry_in, issue_qj)) begin m_vj[free] = alu_result; m_qjb[free] = 0; end
            else if (issue_qj_busy && hit(lsb_broadcast, lsb_entry_in, issue_qj)) begin m_vj[free] = lsb_result; m_qjb[free] = 0; end
            if (issue_qk_busy && hit(alu_broadcast, alu_entry_in, issue_qk)) begin m_vk[free] = alu_result; m_qkb[free] = 0; end
            else if (issue_qk_busy && hit(lsb_broadcast, lsb_entry_in, issue_qk)) begin m_vk[free] = lsb_result; m_qkb[free] = 0; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_instruction = '0; issue_pc = '0; issue_imm = '0; issue_vj = '0; issue_vk = '0;
        issue_qj_busy = 1'b0; issue_qk_busy = 1'b0; issue_qj = '0; issue_qk = '0; issue_entry = '0;
        alu_broadcast = 1'b0; alu_result = '0; alu_entry_in = '0;
        lsb_broadcast = 1'b0; lsb_result = '0; lsb_entry_in = '0;
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic qjb,
                             input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                             input logic [3:0] qk, input logic [31:0] imm, input logic [3:0] dest);
        issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj;
        issue_vk = vk; issue_qk_busy = qkb; issue_qk = qk; issue_imm = imm; issue_entry = dest;
        issue_instruction = $urandom; issue_pc = $urandom;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        assert_reset();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL reset_nc: got %0b expected 0", new_calculate); end
        n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", rs_full); end
        n_checks++; if ({out_op, out_instruction, out_vj, out_vk, out_pc, out_imm, out_entry} !== '0) begin
            n_fail++; $display("FAIL reset_outs: got op=%0h vj=%0h entry=%0h expected all zero", out_op, out_vj, out_entry); end
        release_reset();
    endtask

    task automatic test_issue_ready();
        set_issue(ADDI, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd3, 4'd1);
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL addi_early: got %0b expected 0", new_calculate); end
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1) begin n_fail++; $display("FAIL addi_nc: got %0b expected 1", new_calculate); end
        n_checks++; if (out_op !== 6'(ADDI) || out_vj !== 32'd5 || out_imm !== 32'd3 || out_entry !== 4'd1) begin
            n_fail++; $display("FAIL addi_fields: got op=%0d vj=%0h imm=%0h entry=%0d expected op=%0d vj=5 imm=3 entry=1",
                               out_op, out_vj, out_imm, out_entry, 6'(ADDI)); end
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL addi_once: got %0b expected 0", new_calculate); end
    endtask

    task automatic test_wakeup();
        set_issue(ADD, 32'd0, 1'b1, 4'd7, 32'd2, 1'b0, 4'd0, 32'd0, 4'd4);
        tick();
        idle_inputs();
        lsb_broadcast = 1'b1; lsb_entry_in = 4'd6; lsb_result = 32'hDEAD;
        tick();
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL wake_foreign_tag: got %0b expected 0", new_calculate); end
        alu_broadcast = 1'b1; alu_entry_in = 4'd7; alu_result = 32'h10;
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle: got %0b expected 0", new_calculate); end
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_vj !== 32'h10 || out_vk !== 32'd2 || out_entry !== 4'd4) begin
            n_fail++; $display("FAIL wake_dispatch: got nc=%0b vj=%0h vk=%0h entry=%0d expected nc=1 vj=10 vk=2 entry=4",
                               new_calculate, out_vj, out_vk, out_entry); end
    endtask

    task automatic test_bypass();
        set_issue(ADD, 32'h0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 32'd0, 4'd5);
        lsb_broadcast = 1'b1; lsb_entry_in = 4'd2; lsb_result = 32'hAB;
        tick();
        idle_inputs();
        set_issue(SUB, 32'h0, 1'b1, 4'd3, 32'd1, 1'b0, 4'd0, 32'd0, 4'd6);
        alu_broadcast = 1'b1; alu_entry_in = 4'd3; alu_result = 32'h11;
        lsb_broadcast = 1'b1; lsb_entry_in = 4'd3; lsb_result = 32'h22;
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_vj !== 32'hAB || out_entry !== 4'd5) begin
            n_fail++; $display("FAIL bypass_lsb: got nc=%0b vj=%0h entry=%0d expected nc=1 vj=ab entry=5",
                               new_calculate, out_vj, out_entry); end
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_vj !== 32'h11 || out_entry !== 4'd6) begin
            n_fail++; $display("FAIL bypass_alu_prio: got nc=%0b vj=%0h entry=%0d expected nc=1 vj=11 entry=6",
                               new_calculate, out_vj, out_entry); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) begin
            set_issue(XOR, 32'd0, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'(i), 4'(i));
            tick();
            if (i == RS - 2) begin
                n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %0b expected 0", rs_full); end
            end
        end
        n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %0b expected 1", rs_full); end
        set_issue(LUI, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 4'd15);
        tick();
        n_checks++; if (rs_full !== 1'b1 || new_calculate !== 1'b0) begin
            n_fail++; $display("FAIL full_ignore: got full=%0b nc=%0b expected full=1 nc=0", rs_full, new_calculate); end
        idle_inputs();
        alu_broadcast = 1'b1; alu_entry_in = 4'd9; alu_result = 32'h99;
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL full_no_intruder: got %0b expected 0", new_calculate); end
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_vj !== 32'h99 || out_entry !== 4'd9 || rs_full !== 1'b0) begin
            n_fail++; $display("FAIL full_wake9: got nc=%0b vj=%0h entry=%0d full=%0b expected nc=1 vj=99 entry=9 full=0",
                               new_calculate, out_vj, out_entry, rs_full); end
        clear = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            set_issue(OR, 32'd0, 1'b1, 4'(10 + i), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
            tick();
        end
        set_issue(ANDI, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 4'd8);
        alu_broadcast = 1'b1; alu_entry_in = 4'd10; alu_result = 32'h55;
        clear = 1'b1;
        tick();
        n_checks++; if (rs_full !== 1'b0 || new_calculate !== 1'b0) begin
            n_fail++; $display("FAIL clear_now: got full=%0b nc=%0b expected 0 0", rs_full, new_calculate); end
        idle_inputs();
        for (int t = 0; t < 8; t++) begin
            alu_broadcast = 1'b1; alu_entry_in = 4'(2 * t); alu_result = 32'h77;
            lsb_broadcast = 1'b1; lsb_entry_in = 4'(2 * t + 1); lsb_result = 32'h78;
            tick();
            n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL clear_stale_%0d: got %0b expected 0", t, new_calculate); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_dispatch_order();
        for (int i = 0; i < 8; i++) begin
            set_issue(SLT, 32'd0, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
            tick();
        end
        idle_inputs();
        alu_broadcast = 1'b1; alu_entry_in = 4'd1; alu_result = 32'h101;
        lsb_broadcast = 1'b1; lsb_entry_in = 4'd4; lsb_result = 32'h104;
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL order_pre: got %0b expected 0", new_calculate); end
        idle_inputs();
        alu_broadcast = 1'b1; alu_entry_in = 4'd6; alu_result = 32'h106;
        tick();
        idle_inputs();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd1) begin
            n_fail++; $display("FAIL order_1: got nc=%0b entry=%0d expected nc=1 entry=1", new_calculate, out_entry); end
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd4 || out_vj !== 32'h104) begin
            n_fail++; $display("FAIL order_4: got nc=%0b entry=%0d vj=%0h expected nc=1 entry=4 vj=104", new_calculate, out_entry, out_vj); end
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd6) begin
            n_fail++; $display("FAIL order_6: got nc=%0b entry=%0d expected nc=1 entry=6", new_calculate, out_entry); end
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL order_end: got %0b expected 0", new_calculate); end
        clear = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_rdy_stall();
        set_issue(SLTU, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0, 4'd3);
        tick();
        idle_inputs();
        rdy = 1'b0;
        set_issue(SRL, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 4'd5);
        alu_broadcast = 1'b1; alu_entry_in = 4'd0; alu_result = 32'h1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: got %0b expected 0", t, new_calculate); end
        end
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd3) begin
            n_fail++; $display("FAIL stall_resume: got nc=%0b entry=%0d expected nc=1 entry=3", new_calculate, out_entry); end
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL stall_no_issue: got %0b expected 0", new_calculate); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 3; i++) begin
            set_issue(ADD, 32'(i), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
            tick();
        end
        idle_inputs();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd2) begin
            n_fail++; $display("FAIL mid_before: got nc=%0b entry=%0d expected nc=1 entry=2", new_calculate, out_entry); end
        assert_reset();
        n_checks++; if (new_calculate !== 1'b0 || rs_full !== 1'b0 || out_op !== 6'd0 || out_vj !== 32'd0) begin
            n_fail++; $display("FAIL mid_async: got nc=%0b full=%0b op=%0d vj=%0h expected all zero",
                               new_calculate, rs_full, out_op, out_vj); end
        release_reset();
        set_issue(ADDI, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 4'd9);
        tick();
        idle_inputs();
        tick();
        n_checks++; if (new_calculate !== 1'b1 || out_entry !== 4'd9) begin
            n_fail++; $display("FAIL mid_first_issue: got nc=%0b entry=%0d expected nc=1 entry=9", new_calculate, out_entry); end
        tick();
        n_checks++; if (new_calculate !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %0b expected 0", new_calculate); end
    endtask

    task automatic test_random();
        idle_inputs();
        assert_reset();
        release_reset();
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 59) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_op = 6'($urandom_range(0, 36));
            issue_instruction = $urandom; issue_pc = $urandom; issue_imm = $urandom;
            issue_vj = $urandom; issue_vk = $urandom;
            issue_qj_busy = ($urandom_range(0, 1) == 1); issue_qj = 4'($urandom_range(0, 15));
            issue_qk_busy = ($urandom_range(0, 2) == 0); issue_qk = 4'($urandom_range(0, 15));
            issue_entry = 4'($urandom_range(0, 15));
            alu_broadcast = ($urandom_range(0, 1) == 1); alu_entry_in = 4'($urandom_range(0, 15)); alu_result = $urandom;
            lsb_broadcast = ($urandom_range(0, 1) == 1); lsb_entry_in = 4'($urandom_range(0, 15)); lsb_result = $urandom;
            tick();
            n_checks++; if (new_calculate !== m_nc) begin n_fail++; $display("FAIL rand_nc cyc %0d: got %0b expected %0b", c, new_calculate, m_nc); end
            n_checks++; if (rs_full !== ($countones({m_busy[0], m_busy[1], m_busy[2], m_busy[3], m_busy[4], m_busy[5], m_busy[6], m_busy[7],
                                                      m_busy[8], m_busy[9], m_busy[10], m_busy[11], m_busy[12], m_busy[13], m_busy[14], m_busy[15]}) == RS)) begin
                n_fail++; $display("FAIL rand_full cyc %0d: got %0b", c, rs_full); end
            n_checks++; if ({out_op, out_instruction, out_vj, out_vk, out_pc, out_imm, out_entry} !==
                            {mo_op, mo_ins, mo_vj, mo_vk, mo_pc, mo_imm, mo_dest}) begin
                n_fail++; $display("FAIL rand_outs cyc %0d: got op=%0h vj=%0h vk=%0h entry=%0h expected op=%0h vj=%0h vk=%0h entry=%0h",
                                   c, out_op, out_vj, out_vk, out_entry, mo_op, mo_vj, mo_vk, mo_dest); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_issue_ready();
        test_wakeup();
        test_bypass();
        test_full();
        test_clear();
        test_dispatch_order();
        test_rdy_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
